// File: rtl/run_sequencer_if.sv
// Run-control bus between the testbench/decoder side and run_sequencer.
// master drives Start/ProgSel/Halt/Stall; slave (the sequencer) drives the PC controls.
interface run_sequencer_if #(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic [1:0]       prog_sel;
  logic             halt;
  logic             stall;
  logic             pc_load;
  logic [PC_W-1:0]  pc_init;
  logic             count_en;
  logic             done;
  logic [CNT_W-1:0] cycle_count;
  logic             timeout;

  modport master (
    output start, prog_sel, halt, stall,
    input  pc_load, pc_init, count_en, done, cycle_count, timeout
  );

  modport slave (
    input  start, prog_sel, halt, stall,
    output pc_load, pc_init, count_en, done, cycle_count, timeout
  );
endinterface

// File: rtl/run_sequencer.sv
// Run-control FSM for the 3BC processor: loads the PC with the selected entry
// address on a Start falling edge, enables counting until Halt, then reports Done.
// Keeps a saturating per-run cycle count.
// Optional watchdog: define RUN_WATCHDOG_EN to end a run when the count reaches LIMIT.
module run_sequencer #(
  parameter int unsigned      PC_W        = 10,
  parameter int unsigned      CNT_W       = 16,
  parameter logic [PC_W-1:0]  START_ADDR0 = PC_W'(0),
  parameter logic [PC_W-1:0]  START_ADDR1 = PC_W'(128),
  parameter logic [PC_W-1:0]  START_ADDR2 = PC_W'(256),
  parameter logic [CNT_W-1:0] LIMIT       = {CNT_W{1'b1}}
) (
  input logic            clk,
  input logic            rst_n,
  run_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic             start_q;
  logic [PC_W-1:0]  pc_init_q, pc_init_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [PC_W-1:0]  sel_addr;
  logic             start_fall, start_rise;
  logic             halt_exit, wd_exit;

  assign start_fall = start_q & ~bus.start;
  assign start_rise = ~start_q & bus.start;

  // Saturating increment: the count sticks at all-ones instead of wrapping.
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // Halt is only honoured once Stall has dropped.
  assign halt_exit = (state_q == StRun) && bus.halt && !bus.stall;

`ifdef RUN_WATCHDOG_EN
  logic timeout_q, timeout_d;

  // Fires on the edge where the count reaches LIMIT, mirroring a Halt.
  assign wd_exit = (state_q == StRun) && (cnt_inc == LIMIT);

  // Timeout is set on a watchdog exit and cleared when a new run is loaded.
  always_comb begin
    timeout_d = timeout_q;
    if (state_q == StIdle && start_fall) begin
      timeout_d = 1'b0;
    end else if (state_q == StRun && !start_rise && wd_exit) begin
      timeout_d = 1'b1;
    end
  end

  // Timeout register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  logic unused_limit;

  assign wd_exit      = 1'b0;
  assign unused_limit = ^LIMIT;
  assign bus.timeout  = 1'b0;
`endif

  // Entry address select; code 3 falls back to program 0.
  always_comb begin
    sel_addr = START_ADDR0;
    case (bus.prog_sel)
      2'd1:    sel_addr = START_ADDR1;
      2'd2:    sel_addr = START_ADDR2;
      default: sel_addr = START_ADDR0;
    endcase
  end

  // State register and Start edge sampler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= bus.start;
    end
  end

  // Next-state logic; a Start rise aborts LOAD/RUN and ends DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (start_fall) state_d = StLoad;
      StLoad: state_d = start_rise ? StIdle : StRun;
      StRun: begin
        if (start_rise) begin
          state_d = StIdle;
        end else if (halt_exit || wd_exit) begin
          state_d = StDone;
        end
      end
      StDone: if (start_rise) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs, except CountEn which follows Stall within the cycle.
  always_comb begin
    bus.pc_load  = 1'b0;
    bus.count_en = 1'b0;
    bus.done     = 1'b0;
    case (state_q)
      StLoad:  bus.pc_load  = 1'b1;
      StRun:   bus.count_en = !bus.stall;
      StDone:  bus.done     = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: latch entry address and clear count at run start;
  // count every RUN cycle except the one that aborts.
  always_comb begin
    pc_init_d = pc_init_q;
    cnt_d     = cnt_q;
    if (state_q == StIdle && start_fall) begin
      pc_init_d = sel_addr;
      cnt_d     = '0;
    end else if (state_q == StRun && !start_rise) begin
      cnt_d = cnt_inc;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_init_q <= '0;
      cnt_q     <= '0;
    end else begin
      pc_init_q <= pc_init_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.pc_init     = pc_init_q;
  assign bus.cycle_count = cnt_q;

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
Synchronous run-control FSM for the 3BC processor. It owns the program counter's count enable and initial load. Start/Halt handling is in one clock domain: it detects the testbench Start handshake, loads the PC with the selected program's entry address, enables counting until the decoder signals Halt, then reports Done. It also keeps a per-run cycle count that the testbench reads.

Parameters:
PC_W, 10, program counter / address width
CNT_W, 16, cycle counter width
START_ADDR0, 0, entry address of program 0
START_ADDR1, 128, entry address of program 1
START_ADDR2, 256, entry address of program 2
LIMIT, 16'hFFFF, watchdog cycle limit (used only with the optional feature)

Ports:
Clk  in  1  system clock, all state updates on posedge
Reset  in  1  asynchronous, active-low; 0 forces the reset state immediately
Start  in  1  testbench run request; high = hold/load phase, falling edge = begin run
ProgSel  in  2  program select, sampled in the cycle the Start falling edge is detected; 3 maps to START_ADDR0
Halt  in  1  from decoder, current instruction is halt
Stall  in  1  freezes the PC without leaving RUN
PcLoad  out  1  one-cycle pulse: the PC loads PcInit
PcInit  out  PC_W  entry address for PcLoad
CountEn  out  1  PC increment/branch enable
Done  out  1  run finished, held until the next Start rise
CycleCount  out  CNT_W  cycles spent in RUN for the current/last run
Timeout  out  1  watchdog fired (0 constantly when the feature is compiled out)

Behaviour:
- Reset (Reset=0, async):
  - state=IDLE; start_q=0; PcLoad=0; PcInit=0; CountEn=0; Done=0; CycleCount=0; Timeout=0.
- Start is sampled into start_q each Clk. The falling edge is the registered condition start_q=1 and Start=0. A rising edge is start_q=0 and Start=1.
- States:
  - IDLE: all enables 0.
    - Start falling edge -> LOAD.
    - Latch PcInit from ProgSel on that edge.
    - Clear CycleCount and Timeout.
  - LOAD (exactly 1 cycle):
    - PcLoad=1, CountEn=0.
    - Next state RUN.
  - RUN: CountEn = not Stall.
    - CycleCount increments every RUN cycle, including stalled ones, and saturates at all-ones (no wrap).
    - Halt=1 and Stall=0 -> DONE. The halt cycle itself is counted, and CountEn is 0 from the next cycle on.
    - Halt=1 with Stall=1 is ignored until Stall drops.
  - DONE:
    - Done=1, CountEn=0, CycleCount frozen.
    - Start rising edge -> IDLE (Done drops the next cycle).
- Registered-output latency:
  - Start falling edge at sample edge N -> PcLoad high in cycle N+1 -> CountEn high from cycle N+2.
  - Halt sampled at edge M -> CountEn low and Done high from M+1.
- Start rising edge in LOAD or RUN aborts the run:
  - go to IDLE next cycle; CountEn=0; Done stays 0.
  - CycleCount keeps its value until the next run begins.
- A Start falling edge in DONE without a prior rise is impossible by the edge definition; Start held low in DONE keeps DONE.
- Halt and Stall are ignored outside RUN.
- Reset asserted mid-run: all outputs drop asynchronously to their reset values. No PcLoad pulse is emitted on reset release until a new Start falling edge.

Optional Feature:
Macro RUN_WATCHDOG_EN.
- Defined: in RUN, when CycleCount reaches LIMIT, the FSM enters DONE with Done=1 and Timeout=1 on the next cycle, exactly as for a Halt. Timeout clears on the next LOAD entry or on reset.
- Undefined: no comparator is built, Timeout is tied 0, and RUN exits only on Halt or Start rise.

Test Plan:
- Reset=0 mid-RUN with CountEn=1 -> all outputs 0 immediately, state IDLE after Reset=1, no PcLoad without a new Start fall.
- Start 1->0, ProgSel=1 -> PcLoad pulse 1 cycle with PcInit=128, CountEn=1 from the following cycle, Done=0.
- Halt asserted 20 cycles after CountEn rises -> CountEn=0, Done=1 next cycle, CycleCount=21 (halt cycle included); Start 0->1 -> Done=0 one cycle later.
- Stall=1 for 3 RUN cycles with Halt=1 during the stall -> CountEn=0 during the stall, no DONE until Stall=0, CycleCount includes the 3 stall cycles.
- Start 0->1 while in RUN at CycleCount=5 -> IDLE, CountEn=0, Done=0, CycleCount holds 5; next Start fall clears it to 0.
- RUN_WATCHDOG_EN with LIMIT=50 and Halt never asserted -> Done=1 and Timeout=1 when CycleCount=50; without the macro, still RUN at cycle 60 with Timeout=0.
